pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the en/flush pair of each pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves icache wait, dcache wait, load-use hazards, EX-stage redirects and halt drain.
- Keeps saturating performance counters for stall cycles and redirect flushes.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt (saturating).

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset; asynchronous, active-low
ihit  in  1  icache returned instruction this cycle
dhit  in  1  dcache completed access this cycle
exmem_dREN  in  1  load in MEM stage
exmem_dWEN  in  1  store in MEM stage
exmem_halt  in  1  halt instruction in MEM stage
memwb_halt  in  1  halt instruction at MEM/WB output
idex_dREN  in  1  load in EX stage
idex_rd  in  5  EX-stage destination register
ifid_rs1  in  5  ID-stage source 1
ifid_rs2  in  5  ID-stage source 2
ex_redirect  in  1  EX resolved taken branch/jump mispredict; PC loads target
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes (bubble)
halt  out  1  sticky processor-halted flag
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED
flush_cnt  out  CNT_W  count of accepted ex_redirect events

Behaviour:
- Async reset: state=RUN, halt=0, stall_cnt=0, flush_cnt=0. All en/flush outputs are 0 while nRST=0. Reset mid-stall or mid-drain returns to RUN immediately.
- States: RUN, DWAIT, DRAIN, HALTED. Outputs are combinational from state and inputs; zero added latency.
- dmem_op = exmem_dREN | exmem_dWEN.
- dstall = dmem_op & ~dhit. Outputs: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=0, memwb_flush=1 (WB receives a bubble). All other flushes 0.
- Priority in RUN (highest first): dstall > exmem_halt > ex_redirect > load-use > istall > normal.
- exmem_halt: pc_en=0; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1; next state DRAIN.
- ex_redirect: pc_en=1 regardless of ihit; ifid_flush=idex_flush=1; exmem_en=memwb_en=1. flush_cnt+1.
- load-use = idex_dREN & idex_rd!=0 & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2): pc_en=0; ifid_en=0; idex_flush=1; exmem_en=memwb_en=1.
- istall = ~ihit: pc_en=0; ifid_flush=1; idex_en=exmem_en=memwb_en=1.
- normal: all en=1, all flush=0.
- en and flush are never both 1 on the same latch. When flush=1, that latch's en=0.
- Transitions:
  - RUN -> DWAIT on dstall.
  - DWAIT: same outputs as dstall until dhit. On the dhit cycle the RUN rules apply with dstall=0 (the pipeline advances), and the state returns to RUN.
  - RUN -> DRAIN on exmem_halt (when no dstall).
  - DRAIN: pc_en=0; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1. Ignores ex_redirect, ihit and load-use.
  - DRAIN -> HALTED when memwb_halt=1.
  - HALTED: every en=0 and every flush=0; halt=1. Leaves only by reset.
- An ex_redirect asserted during dstall is ignored; EX is frozen, so the input persists and is taken once the stall clears. flush_cnt increments only when the redirect is accepted.
- stall_cnt increments in each RUN/DWAIT/DRAIN cycle with pc_en=0.
- Both counters saturate at all-ones and do not wrap.
- halt register sets on the DRAIN->HALTED edge.

Test Plan:
- Reset, then ihit=1, no hazards -> all en=1, all flush=0, stall_cnt=0. Assert nRST=0 mid-run -> outputs 0 and counters 0 immediately (asynchronous).
- Load in MEM, dhit low for 3 cycles then high -> three cycles of pc_en=0, memwb_flush=1, state DWAIT; all en=1 on the dhit cycle; stall_cnt=3.
- idex_dREN=1, idex_rd=5, ifid_rs2=5 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Repeat with idex_rd=0 -> no stall.
- ex_redirect=1 with ihit=0 and a simultaneous load-use -> pc_en=1, ifid_flush=idex_flush=1, flush_cnt=1. Then ex_redirect during dstall -> no flush and flush_cnt unchanged until dhit.
- exmem_halt=1 -> DRAIN: exmem_flush=1, memwb_en=1. Next cycle memwb_halt=1 -> HALTED, halt=1, all en/flush=0; stays halted with ihit/dhit toggling.
- Force stall_cnt to all-ones (CNT_W=4 build) and hold ihit=0 -> counter stays 4'hF and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives latch en/flush pairs and PC enable,
// walks RUN/DWAIT/DRAIN/HALTED, and keeps saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_halt,
    input  logic             memwb_halt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

    state_t           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic dmem_op, dstall, load_use, hold, run_rules, redirect_acc;

    assign dmem_op  = exmem_dREN | exmem_dWEN;
    assign dstall   = dmem_op & ~dhit;
    assign load_use = idex_dREN & (idex_rd != 5'd0) &
                      ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    // DWAIT keeps freezing until dhit even if the MEM-stage request lines wobble.
    assign hold         = ((state_q == RUN) & dstall) | ((state_q == DWAIT) & ~dhit);
    assign run_rules    = ((state_q == RUN) | (state_q == DWAIT)) & ~hold;
    assign redirect_acc = run_rules & ~exmem_halt & ex_redirect;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (dstall)          state_d = DWAIT;
                else if (exmem_halt) state_d = DRAIN;
            end
            DWAIT: begin
                if (!dhit)           state_d = DWAIT;
                else if (exmem_halt) state_d = DRAIN;
                else                 state_d = RUN;
            end
            DRAIN:   if (memwb_halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (nRST) begin
            if (hold) begin
                memwb_flush = 1'b1;
            end else if (state_q == DRAIN || (run_rules && exmem_halt)) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
            end else if (run_rules) begin
                if (ex_redirect) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (load_use) begin
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (!ihit) begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
        end
    end

    always_comb begin
        halt_d      = halt_q | ((state_q == DRAIN) & memwb_halt);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != HALTED) && !pc_en && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect_acc && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    assign halt      = halt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
